// File: rtl/bus_io_responder.sv
// Register-file I/O target on the system bus. It captures the address phase,
// takes write data the following cycle, inserts wait states and answers with a
// one-cycle io_ready pulse.
module bus_io_responder #(
  parameter int MEM_WIDTH   = 8,
  parameter int MEM_DEPTH   = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_DEPTH-1:0] bus_addr,
  input  logic                 io_write_en,
  input  logic                 io_read_en,
  input  logic [MEM_WIDTH-1:0] bus_data_write,
  output logic [MEM_WIDTH-1:0] io_data_read,
  output logic                 io_ready,
  output logic                 io_error,
  output logic [2:0]           io_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0]         WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [MEM_DEPTH:0] NUM_REGS_W = (MEM_DEPTH + 1)'(NUM_REGS);

  state_t               state_reg, state_next;
  logic [MEM_DEPTH-1:0] addr_reg, addr_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic                 err_reg, err_next;
  logic                 read_reg, read_next;
  logic [MEM_WIDTH-1:0] data_reg, data_next;
  logic                 ready_reg, ready_next;
  logic                 error_reg, error_next;
  logic [MEM_WIDTH-1:0] rd_data;
  logic [NUM_REGS-1:0]  wr_sel;
  logic [MEM_WIDTH-1:0] reg_file [NUM_REGS];

  // Rejected writes still pass through WDATA but never select a register.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
    assign wr_sel[gi] = (state_reg == WDATA) && !err_reg &&
                        (addr_reg == MEM_DEPTH'(gi));
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_next == MEM_DEPTH'(i)) rd_data = reg_file[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    read_next  = read_reg;
    case (state_reg)
      IDLE: begin
        if (io_write_en || io_read_en) begin
          addr_next = bus_addr;
          err_next  = (io_write_en && io_read_en) || ({1'b0, bus_addr} >= NUM_REGS_W);
          // A strobe conflict follows read timing but performs no access.
          read_next = io_read_en && !io_write_en;
          if (io_write_en && !io_read_en) begin
            state_next = WDATA;
          end else begin
            cnt_next   = WAIT_LOAD;
            state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
      end
      WDATA: begin
        cnt_next   = WAIT_LOAD;
        state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    ready_next = (state_next == RESP);
    error_next = ready_next && err_next;
    data_next  = data_reg;
    if (ready_next && read_next) data_next = err_next ? '0 : rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      read_reg  <= 1'b0;
      data_reg  <= '0;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      read_reg  <= read_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      error_reg <= error_next;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) reg_file[i] <= bus_data_write;
      end
    end
  end

  assign io_data_read = data_reg;
  assign io_ready     = ready_reg;
  assign io_error     = error_reg;
  assign io_state     = {1'b0, state_reg};

endmodule

// File: tb/tb_bus_io_responder.sv
// Scoreboard bench: three responders (WAIT_CYCLES 1, 0, 3) share one stimulus
// stream; each has its own expected-response queue drained by a monitor.
module tb_bus_io_responder;

  logic       clk = 1'b0;
  logic       rst, wr, rd;
  logic [7:0] addr, wdata;
  logic [7:0] rdata [3];
  logic       rdy   [3];
  logic       errs  [3];
  logic [2:0] st    [3];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic       err;
    logic       chk;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq [3][$];
  logic [7:0] mdl [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    exp_t e;

    bus_io_responder #(
      .MEM_WIDTH(8), .MEM_DEPTH(8), .NUM_REGS(16), .WAIT_CYCLES(W)
    ) u_dut (
      .clk(clk), .rst(rst), .bus_addr(addr), .io_write_en(wr), .io_read_en(rd),
      .bus_data_write(wdata), .io_data_read(rdata[gi]), .io_ready(rdy[gi]),
      .io_error(errs[gi]), .io_state(st[gi])
    );

    always @(negedge clk) begin
      if (rdy[gi]) begin
        checks++;
        if (sbq[gi].size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready dut%0d W=%0d cyc=%0d err=%0b data=%02h, required no pulse",
                   gi, W, cyc, errs[gi], rdata[gi]);
        end else begin
          e = sbq[gi].pop_front();
          if (cyc != e.cyc || errs[gi] != e.err || (e.chk && rdata[gi] != e.data)) begin
            errors++;
            $display("FAIL resp dut%0d W=%0d: cyc=%0d err=%0b data=%02h, required cyc=%0d err=%0b data=%02h",
                     gi, W, cyc, errs[gi], rdata[gi], e.cyc, e.err, e.data);
          end else begin
            $display("resp dut%0d W=%0d cyc=%0d err=%0b data=%02h", gi, W, cyc, errs[gi], rdata[gi]);
          end
        end
      end else if (errs[gi]) begin
        checks++;
        errors++;
        $display("FAIL error_without_ready dut%0d cyc=%0d io_error=1, required 0", gi, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_resp(input int base, input logic e_err, input logic e_chk,
                             input logic [7:0] e_data);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.cyc  = base + wc(i);
      e.err  = e_err;
      e.chk  = e_chk;
      e.data = e_data;
      sbq[i].push_back(e);
    end
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      done = (sbq[0].size() == 0) && (sbq[1].size() == 0) && (sbq[2].size() == 0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: responses outstanding %0d/%0d/%0d, required 0",
               sbq[0].size(), sbq[1].size(), sbq[2].size());
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic bad;
    bad = (a >= 8'd16);
    @(posedge clk); #1;
    wr = 1'b1; addr = a;
    expect_resp(cyc + 2, bad, 1'b0, 8'h00);
    @(posedge clk); #1;
    wr = 1'b0; addr = ~a; wdata = d;
    if (!bad) mdl[a[3:0]] = d;
    @(posedge clk); #1;
    wdata = 8'h00;
    wait_done();
  endtask

  task automatic do_read(input logic [7:0] a);
    logic bad;
    bad = (a >= 8'd16);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    expect_resp(cyc + 1, bad, 1'b1, bad ? 8'h00 : mdl[a[3:0]]);
    @(posedge clk); #1;
    rd = 1'b0; addr = ~a;
    wait_done();
  endtask

  task automatic reset_outputs_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_data"},  32'(rdata[i]), 32'h0);
      chk({tag, "_ready"}, 32'(rdy[i]),   32'h0);
      chk({tag, "_error"}, 32'(errs[i]),  32'h0);
      chk({tag, "_state"}, 32'(st[i]),    32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 8'h00; wdata = 8'h00;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;

    // Reset state, then every register reads back zero.
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_zero("reset");
    rst = 1'b0;
    for (int a = 0; a < 16; a++) do_read(8'(a));

    // Write then read.
    do_write(8'h04, 8'hFF);
    do_read(8'h04);

    // Out-of-range accesses leave the register file untouched.
    do_write(8'h20, 8'h5A);
    do_read(8'h20);
    do_write(8'h10, 8'h11);
    for (int a = 0; a < 16; a++) do_read(8'(a));

    // Strobe conflict: error response, no access.
    @(posedge clk); #1;
    wr = 1'b1; rd = 1'b1; addr = 8'h04;
    expect_resp(cyc + 1, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    wait_done();
    do_read(8'h04);

    // Read strobe while busy is ignored: one pulse only.
    do_write(8'h05, 8'h3C);
    @(posedge clk); #1;
    rd = 1'b1; addr = 8'h05;
    expect_resp(cyc + 1, 1'b0, 1'b1, mdl[5]);
    @(posedge clk); #1;
    addr = 8'h06;
    @(posedge clk); #1;
    rd = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);

    // Reset in the write-data cycle aborts the write.
    do_write(8'h03, 8'h77);
    @(posedge clk); #1;
    wr = 1'b1; addr = 8'h03;
    @(posedge clk); #1;
    wr = 1'b0; rst = 1'b1; wdata = 8'hAA;
    @(posedge clk); #1;
    reset_outputs_zero("midreset");
    rst = 1'b0; wdata = 8'h00;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    repeat (6) @(posedge clk);
    do_read(8'h03);

    // Write/read pairs across the whole register file.
    for (int a = 0; a < 16; a++) begin
      do_write(8'(a), 8'(a) ^ 8'hC3);
      do_read(8'(a));
    end

    repeat (6) @(posedge clk);
    for (int i = 0; i < 3; i++) chk("queue_drained", 32'(sbq[i].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_io_responder.md
# bus_io_responder

Responder end of the system bus driven by the bus controller. It sits on the controller's `bus_addr` / `io_write_en` / `io_read_en` / `bus_data_write` outputs and implements a small register-file I/O target. It captures the address phase, then takes write data one cycle later or returns read data. It inserts a programmable number of wait states and signals completion with a one-cycle `io_ready` pulse, flagging bad accesses on `io_error`.

## Interface
Parameters:
- `MEM_WIDTH`, 8 — data bus width in bits.
- `MEM_DEPTH`, 8 — address bus width in bits.
- `NUM_REGS`, 16 — number of implemented registers, at addresses 0..NUM_REGS-1; must be ≤ 2^MEM_DEPTH.
- `WAIT_CYCLES`, 1 — wait states inserted before the response; range 0..15.

Ports (clock and reset first):
- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `bus_addr`  in  MEM_DEPTH  — address; sampled only in the request cycle.
- `io_write_en`  in  1  — write request strobe, one cycle.
- `io_read_en`  in  1  — read request strobe, one cycle.
- `bus_data_write`  in  MEM_WIDTH  — write data; sampled the cycle after the write request.
- `io_data_read`  out  MEM_WIDTH  — read data; registered and held until the next read response.
- `io_ready`  out  1  — one-cycle completion pulse.
- `io_error`  out  1  — asserted with `io_ready` when the access was rejected.
- `io_state`  out  3  — current FSM state, for debug.

## Operation
FSM states and encodings:
- IDLE = 0, WDATA = 1, WAIT = 2, RESP = 3.

IDLE:
- Requests are accepted only in IDLE. Strobes seen in any other state are ignored and produce no response.
- `io_write_en` only: latch `bus_addr` and go to WDATA.
- `io_read_en` only: latch `bus_addr`, load the wait counter with WAIT_CYCLES, then go to WAIT, or go directly to RESP if WAIT_CYCLES = 0.
- Both strobes high: latch the error flag, perform no access, and go to WAIT/RESP on the read timing.
- Address ≥ NUM_REGS: set the error flag. A rejected write still passes through WDATA, but memory is not modified.

WDATA:
- Sample `bus_data_write`.
- If the address is valid, write the register at the end of this cycle.
- Load the wait counter, then go to WAIT, or to RESP if WAIT_CYCLES = 0.

WAIT:
- Decrement the counter each cycle.
- Go to RESP in the cycle the counter reaches 1.

RESP:
- Assert `io_ready` for exactly one cycle and assert `io_error` if the error flag is set.
- On a read, `io_data_read` updates at the RESP edge:
  - valid read: the register value;
  - rejected read: 0.
- A write response leaves `io_data_read` unchanged.
- Always return to IDLE next cycle. The earliest next request is the cycle after RESP.

Reset behaviour:
- State goes to IDLE.
- All NUM_REGS registers, `io_data_read`, `io_ready`, `io_error`, the latched address, the wait counter and the error flag go to 0.
- Reset mid-transaction aborts it: no `io_ready` pulse, and a write not yet committed is lost.

## Timing
- Request cycle T, W = WAIT_CYCLES.
- Write: data sampled at T+1, register updated at the end of T+1, `io_ready` high in cycle T+2+W.
- Read: `io_ready` and valid `io_data_read` in cycle T+1+W.
- A read issued in the cycle after a write's RESP returns the newly written value.
- All outputs are registered; no combinational path from inputs to outputs.
- `io_ready` is never high for two consecutive cycles.
- `io_error` is 0 whenever `io_ready` is 0.
- Address wrap: none. The full MEM_DEPTH-bit address is compared against NUM_REGS; there is no aliasing.
- Strobes held high across multiple cycles count as one request. The extra cycles fall in non-IDLE states and are ignored.

## Test plan
All scenarios use defaults MEM_WIDTH = 8, MEM_DEPTH = 8, NUM_REGS = 16, WAIT_CYCLES = 1.

1. Reset check: pulse `rst`, then read every address 0..15 → each read gives `io_ready` with `io_data_read` = 0x00 and `io_error` = 0. During reset, all outputs are 0 and `io_state` = 0.
2. Write then read: write addr 0x04 (strobe at T), data 0xFF at T+1 → `io_ready` at T+3, `io_error` = 0. Then read 0x04 (strobe at T') → `io_ready` at T'+2 with `io_data_read` = 0xFF.
3. Out-of-range accesses:
   - Write 0x20 with data 0x5A → `io_ready` and `io_error` at T+3, and registers 0..15 are unchanged.
   - Read 0x20 → `io_error` = 1, `io_data_read` = 0x00.
4. Conflict and busy:
   - Both strobes high with addr 0x04 → `io_ready` and `io_error` at T+2, and register 4 is unchanged.
   - A read strobe issued during WAIT → ignored, giving exactly one `io_ready` pulse.
5. Reset mid-write: write strobe to 0x03, then assert `rst` at T+1 together with data 0xAA → no `io_ready`, `io_state` = 0; a later read of 0x03 returns 0x00.
6. Parameter sweep with WAIT_CYCLES = 0 and WAIT_CYCLES = 3: back-to-back write/read pairs on 0x00..0x0F with data = addr XOR 0xC3 → `io_ready` latency matches T+2+W for writes and T+1+W for reads, and every read returns the written data.
